// File: rtl/sc_bit_decoder.sv
// sc_bit_decoder: stochastic-to-binary decoder.
// Counts the ones in a unipolar bitstream over a window of N = 2^IWID valid
// bits and presents the count on a single-entry valid/ready output register.
// Back-to-back windows are supported by sampling iStart at window completion.
// Optional build macro: SC_DEC_BIPOLAR_EN. When defined, the loaded result is
// the bipolar value 2*ones - N in two's complement. Otherwise it is the
// zero-extended ones count.
module sc_bit_decoder #(
  parameter int IWID = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iStart,
  input  logic            iDbit,
  input  logic            iDvld,
  output logic            oBusy,
  output logic [IWID+1:0] oData,
  output logic            oValid,
  input  logic            iReady
);

  // Counter width holds 0..N inclusive, so an all-ones window cannot wrap.
  localparam int CW = IWID + 1;
  localparam int DW = IWID + 2;
  localparam logic [CW-1:0] N_LEN  = CW'(1 << IWID);
  localparam logic [CW-1:0] LAST   = N_LEN - CW'(1);
  localparam logic [DW-1:0] N_DATA = DW'(1 << IWID);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   ones_reg, ones_next;
  logic [CW-1:0]   len_reg, len_next;
  logic [DW-1:0]   data_reg, data_next;
  logic            valid_reg, valid_next;

  logic            out_free;
  logic            load;
  logic [CW-1:0]   load_ones;
  logic [CW-1:0]   ones_sum;

  // Converts a finished ones count into the value presented on oData.
  function automatic logic [DW-1:0] load_value(input logic [CW-1:0] ones);
`ifdef SC_DEC_BIPOLAR_EN
    load_value = ({1'b0, ones} << 1) - N_DATA;
`else
    load_value = {1'b0, ones};
`endif
  endfunction

  // The output register can accept a result if empty or draining this cycle.
  assign out_free = !valid_reg || iReady;
  assign ones_sum = ones_reg + CW'(iDbit);

  // Next-state, counter and output-register logic.
  always_comb begin
    state_next = state_reg;
    ones_next  = ones_reg;
    len_next   = len_reg;
    data_next  = data_reg;
    valid_next = valid_reg;
    load       = 1'b0;
    load_ones  = ones_reg;

    case (state_reg)
      IDLE: begin
        // Bits presented alongside the accepted iStart are not counted.
        if (iStart) begin
          state_next = ACC;
          ones_next  = '0;
          len_next   = '0;
        end
      end

      ACC: begin
        if (iDvld) begin
          if (len_reg == LAST) begin
            // Completion edge: the N-th valid bit is part of the result.
            if (out_free) begin
              load       = 1'b1;
              load_ones  = ones_sum;
              ones_next  = '0;
              len_next   = '0;
              state_next = iStart ? ACC : IDLE;
            end else begin
              // Park the finished count in the counters until the output frees.
              ones_next  = ones_sum;
              len_next   = N_LEN;
              state_next = WAIT;
            end
          end else begin
            ones_next = ones_sum;
            len_next  = len_reg + CW'(1);
          end
        end
      end

      WAIT: begin
        // Incoming bits are dropped here; only the output register matters.
        if (out_free) begin
          load       = 1'b1;
          load_ones  = ones_reg;
          ones_next  = '0;
          len_next   = '0;
          state_next = iStart ? ACC : IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        ones_next  = '0;
        len_next   = '0;
      end
    endcase

    // A load on the handshake edge keeps oValid high with the new data.
    if (load) begin
      data_next  = load_value(load_ones);
      valid_next = 1'b1;
    end else if (valid_reg && iReady) begin
      valid_next = 1'b0;
    end
  end

  // State, counters and output register; reset discards any partial window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ones_reg  <= '0;
      len_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ones_reg  <= ones_next;
      len_reg   <= len_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
    end
  end

  assign oBusy  = (state_reg != IDLE);
  assign oData  = data_reg;
  assign oValid = valid_reg;

endmodule
